// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO register pair.
// Runs one shift-add or restoring-divide iteration per cycle, then sign-fixes into HI/LO.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, state_nxt;

    logic [1:0]         op_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic               b_zero_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   b_mag_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    // op[0]=0 selects the signed variants; op[1]=1 selects divide.
    logic             is_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign is_signed = ~op[0];
    assign a_abs     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_abs     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_nxt;

    // acc holds {partial_hi, multiplier} for multiply and {remainder, quotient} for divide.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_mag_q : '0)};
    assign mul_nxt   = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};
    assign div_nxt   = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                         : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (!op_q[1]) begin
            {fix_hi, fix_lo} = neg_q ? -acc_q : acc_q;
        end else if (b_zero_q) begin
            fix_hi = a_raw_q;
            fix_lo = '1;
        end else begin
            fix_lo = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            fix_hi = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt_q == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
            a_raw_q   <= '0;
            b_mag_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        neg_q     <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        rem_neg_q <= is_signed & src_a[WIDTH-1];
                        b_zero_q  <= (src_b == '0);
                        a_raw_q   <= src_a;
                        b_mag_q   <= b_abs;
                        acc_q     <= {{WIDTH{1'b0}}, a_abs};
                        cnt_q     <= '0;
                    end else begin
                        if (mthi) hi <= src_a;
                        if (mtlo) lo <= src_a;
                    end
                end
                RUN: begin
                    acc_q <= op_q[1] ? div_nxt : mul_nxt;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | hilo_rd | mthi | mtlo);

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer that owns the architectural HI/LO register pair for the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage, runs a WIDTH-cycle shift-add multiply or restoring-divide engine, and writes the 2×WIDTH result into HI/LO. It raises a stall request toward the hazard logic while a HI/LO consumer or a second mul/div instruction must wait.

Parameters:
WIDTH, 32, operand width and HI/LO width; one iteration per bit.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  EX-stage mul/div issue strobe
op  in  2  operation code, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  WIDTH  rs operand, already forwarded
src_b  in  WIDTH  rt operand, already forwarded
mthi  in  1  write src_a into HI
mtlo  in  1  write src_a into LO
hilo_rd  in  1  ID stage holds MFHI or MFLO
busy  out  1  engine active
done  out  1  one-cycle pulse when HI/LO have just been updated by mul/div
stall  out  1  pipeline stall request
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, internal operand/accumulator registers=0. A reset during an operation aborts it and discards any partial result.
- FSM states and transitions:
  - IDLE -> RUN on start=1. At that edge the block latches op, sign flags, and operand magnitudes. Signed ops take absolute values; unsigned ops take operands unchanged. The counter is cleared.
  - RUN performs one iteration per edge for WIDTH edges (counter 0..WIDTH-1), then -> FIX.
  - FIX applies sign correction. At the FIX edge the block writes hi/lo and returns -> IDLE.
- Timing:
  - busy=1 from the edge that accepts start until the FIX edge, i.e. WIDTH+1 cycles.
  - done=1 for exactly the one cycle after the FIX edge.
  - Total latency from the start edge to hi/lo valid is WIDTH+2 edges (34 for WIDTH=32).
- Multiply: unsigned shift-add over 2×WIDTH bits. In FIX, the product is negated if the signed op has operand signs that differ. HI gets the upper WIDTH bits, LO the lower WIDTH bits.
- Divide: restoring division producing an unsigned quotient and remainder.
  - Signed ops: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divide boundary cases:
  - Divide by zero (src_b=0): no fault. Result is LO = all ones, HI = src_a as latched, for both signed and unsigned. Same latency.
  - Signed overflow (-2^(WIDTH-1) / -1): LO = 0x80000000, HI = 0.
- mthi/mtlo:
  - In IDLE, the register is written at the next edge and is visible the following cycle.
  - While busy, they are ignored; stall covers them.
  - Priority in IDLE: start > mthi/mtlo. Simultaneous mthi and mtlo writes both registers.
- start while busy: ignored, and the stall request holds the instruction in place.
- stall is combinational: stall = busy & (start | hilo_rd | mthi | mtlo). stall=0 in IDLE. It is also 0 in the done cycle, so MFHI/MFLO read the new values.
- hi/lo change only at reset, at the FIX edge, or on an accepted mthi/mtlo.

Test Plan:
- MULT src_a=7, src_b=0xFFFFFFFD (-3): busy is high for 33 cycles, done pulses at edge 34 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- Divide boundaries:
  - DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- While busy, hold hilo_rd=1 -> stall=1 every busy cycle and stall=0 in the done cycle. A second start asserted mid-operation -> stall=1 and no restart; the first result is unaffected.
- IDLE mthi with src_a=0xA5A5A5A5, next cycle mtlo with src_a=0x5A5A5A5A -> hi/lo hold those values. mthi asserted while busy -> hi is unchanged.
- Start MULT, assert rst at iteration 10 -> hi=lo=0, busy=0, done=0 immediately. After release, a fresh MULT 3×4 -> lo=12, hi=0 after 34 edges.
